// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg -- shared definitions for multi-cycle arithmetic blocks.
//   mult_state_e : control state encoding (IDLE/CALC/DONE), shared so other
//                  multi-cycle arithmetic blocks decode the same values.
//   MULT_A_W_DEF : default multiplicand width.
//   MULT_B_W_DEF : default multiplier width (also the CALC iteration count).
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  localparam int unsigned MULT_A_W_DEF = 8;
  localparam int unsigned MULT_B_W_DEF = 8;

endpackage

// File: rtl/mult_abs.sv
// mult_abs -- conditional two's-complement negate, used both as |x| on the
// operands and as the final sign fix-up of the product.
//   W   : input width.
//   x   : input value.
//   en  : negate enable. When set, x is sign-extended and negated, so for a
//         negative x the result is |x|; for a non-negative x (the final
//         fix-up) the result is -x.
//   mag : W+1-bit result, wide enough that the most-negative input yields a
//         correct positive magnitude.
//   neg : high when the value was negated.
module mult_abs #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] x,
  input  logic         en,
  output logic [W:0]   mag,
  output logic         neg
);

  logic [W:0] ext;

  // The extension bit only matters when negating a negative operand; for an
  // unconditional pass-through it is a zero extension.
  assign ext = {en & x[W-1], x};
  assign mag = en ? ((~ext) + (W+1)'(1)) : ext;
  assign neg = en;

endmodule

// File: rtl/mult_seq.sv
// mult_seq -- sequential shift-and-add multiplier with valid/ready handshakes.
// Operands are converted to magnitude + sign on accept, multiplied over
// exactly B_W CALC cycles (data independent), and the product is sign
// corrected as it is loaded into c on entry to DONE.
//   sys_clk     : clock, rising edge.
//   sys_rst     : asynchronous active-high reset.
//   in_valid    : a, b, mode_signed are valid.
//   in_ready    : block is IDLE and can accept operands.
//   a, b        : multiplicand (A_W bits), multiplier (B_W bits).
//   mode_signed : 1 = two's-complement operands, 0 = unsigned.
//   out_valid   : c holds a finished product (state DONE).
//   out_ready   : consumer takes the product.
//   c           : A_W+B_W-bit product, held until the output handshake.
//   busy        : high in any state other than IDLE.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int unsigned A_W = MULT_A_W_DEF,
  parameter int unsigned B_W = MULT_B_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             mode_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [A_W+B_W-1:0] c,
  output logic             busy
);

  localparam int unsigned P_W = A_W + B_W;
  localparam int unsigned CW  = $clog2(B_W + 1);
  localparam logic [CW-1:0] LAST = CW'(B_W - 1);

  mult_state_e     state, state_nxt;
  logic            accept, calc_last;

  logic [CW-1:0]   cnt;
  logic [P_W-1:0]  mcand;
  logic [B_W:0]    mplier;
  logic [P_W-1:0]  acc, acc_next;
  logic            sign_r;
  logic [P_W-1:0]  c_r;

  logic [A_W:0]    mag_a;
  logic [B_W:0]    mag_b;
  logic            neg_a, neg_b;
  logic [P_W:0]    mag_c;
  logic            neg_c;
  logic            unused_c;

  mult_abs #(.W(A_W)) u_abs_a (
    .x   (a),
    .en  (mode_signed & a[A_W-1]),
    .mag (mag_a),
    .neg (neg_a)
  );

  mult_abs #(.W(B_W)) u_abs_b (
    .x   (b),
    .en  (mode_signed & b[B_W-1]),
    .mag (mag_b),
    .neg (neg_b)
  );

  // Final fix-up operates on the accumulator value being written this cycle,
  // so c is ready on the same edge that enters DONE.
  mult_abs #(.W(P_W)) u_neg_c (
    .x   (acc_next),
    .en  (sign_r),
    .mag (mag_c),
    .neg (neg_c)
  );

  // Magnitude is at most 2^(P_W-2) when negated, so the extension bit and
  // the negate flag carry no extra information here.
  assign unused_c = mag_c[P_W] ^ neg_c;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign c        = c_r;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    calc_last = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == LAST) begin
          calc_last = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      sign_r <= 1'b0;
      c_r    <= '0;
    end else if (accept) begin
      cnt    <= '0;
      mcand  <= P_W'(mag_a);
      mplier <= mag_b;
      acc    <= '0;
      sign_r <= neg_a ^ neg_b;
    end else if (state == CALC) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (calc_last) begin
        c_r <= mag_c[P_W-1:0];
      end
    end
  end

endmodule
